// File: rtl/y86_seq_controller.sv
// Y86-64 stage sequencer: owns PC/status/retire count; 6 cycles per instruction, MEMORY stretched by req/ack.
// Backpressure: MEMORY holds mem_req until mem_ack or MEM_TIMEOUT cycles elapse (ADR fault).
module y86_seq_controller #(
    parameter int                PC_W        = 64,
    parameter logic [PC_W-1:0]   RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              cnd,
    input  logic [PC_W-1:0]   valC,
    input  logic [PC_W-1:0]   valP,
    input  logic [PC_W-1:0]   valM,
    input  logic              mem_ack,
    input  logic              dmem_error,
    output logic [5:0]        stage_en,
    output logic              mem_req,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        icode_q, icode_d;
    logic              cnd_q, cnd_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [2:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              is_mem;

    always_comb begin
        is_mem = 1'b0;
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
            default:                            is_mem = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            icode_q <= 4'h0;
            cnd_q   <= 1'b0;
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        cnd_d   = cnd_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALTED;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                cnd_d   = cnd;
                wait_d  = '0;
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (!is_mem) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ack) begin
                    wait_d = '0;
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // Last allowed wait cycle passed without ack.
                    stat_d  = STAT_ADR;
                    state_d = S_HALTED;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_FETCH;
                case (icode_q)
                    4'h0: begin
                        stat_d  = STAT_HLT;
                        state_d = S_HALTED;
                    end
                    4'h7:    pc_d = cnd_q ? valC : valP;
                    4'h8:    pc_d = valC;
                    4'h9:    pc_d = valM;
                    default: pc_d = valP;
                endcase
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_HALTED;
        endcase
    end

    always_comb begin
        stage_en = 6'b000000;
        case (state_q)
            S_FETCH:     stage_en = 6'b000001;
            S_DECODE:    stage_en = 6'b000010;
            S_EXECUTE:   stage_en = 6'b000100;
            S_MEMORY:    stage_en = 6'b001000;
            S_WRITEBACK: stage_en = 6'b010000;
            S_PCUPD:     stage_en = 6'b100000;
            default:     stage_en = 6'b000000;
        endcase
    end

    assign mem_req     = (state_q == S_MEMORY) && is_mem;
    assign halted      = (state_q == S_HALTED);
    assign pc          = pc_q;
    assign stat        = stat_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Randomized bench for y86_seq_controller against an instruction-level model.
module tb_y86_seq_controller;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic        instr_valid, imem_error, cnd, mem_ack, dmem_error;
    logic [63:0] valC, valP, valM;
    logic [5:0]  stage_en;
    logic        mem_req, halted;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [31:0] instr_count;

    y86_seq_controller dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .instr_valid(instr_valid),
        .imem_error(imem_error), .cnd(cnd), .valC(valC), .valP(valP), .valM(valM),
        .mem_ack(mem_ack), .dmem_error(dmem_error), .stage_en(stage_en),
        .mem_req(mem_req), .pc(pc), .stat(stat), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  se;
        logic        mr;
        logic [63:0] pc;
        logic [2:0]  stat;
        logic        hl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          fails  = 0;
    int          obs_mreq = 0;
    int          obs_busy = 0;

    // Instruction-level model state
    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    logic        m_halted;
    logic [31:0] m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("stage_en",    64'(stage_en),    64'(e.se));
            chk("mem_req",     64'(mem_req),     64'(e.mr));
            chk("pc",          pc,               e.pc);
            chk("stat",        64'(stat),        64'(e.stat));
            chk("halted",      64'(halted),      64'(e.hl));
            chk("instr_count", 64'(instr_count), 64'(e.cnt));
        end
        if (mem_req === 1'b1) obs_mreq++;
        if (stage_en !== 6'b0) obs_busy++;
    end

    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
               (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    endfunction

    task automatic model_reset();
        m_pc = 64'h0; m_stat = 3'd1; m_halted = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic noise();
        icode       = 4'($urandom);
        instr_valid = 1'($urandom);
        imem_error  = 1'($urandom);
        cnd         = 1'($urandom);
        mem_ack     = 1'($urandom);
        dmem_error  = 1'($urandom);
        valC        = {$urandom, $urandom};
        valP        = {$urandom, $urandom};
        valM        = {$urandom, $urandom};
    endtask

    // Advance one cycle and record what the DUT must show during it.
    task automatic step(input logic [5:0] se, input logic mr);
        exp_t e;
        @(posedge clk); #1;
        rst_n = 1'b1;
        e.se = se; e.mr = mr; e.pc = m_pc; e.stat = m_stat; e.hl = m_halted; e.cnt = m_cnt;
        expq.push_back(e);
        noise();
    endtask

    task automatic sync();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
    endtask

    task automatic halted_cycles(input int n);
        repeat (n) step(6'h00, 1'b0);
    endtask

    // ack_at: MEMORY cycle (1-based) carrying mem_ack, 0 = never; abort_at: MEMORY cycle with rst_n low.
    task automatic run_instr(input logic [3:0] ic, input logic vld, input logic ierr,
                             input logic c, input int ack_at, input logic derr,
                             input logic [63:0] vc, input logic [63:0] vp,
                             input logic [63:0] vm, input int abort_at);
        step(6'h01, 1'b0);
        icode = ic; instr_valid = vld; imem_error = ierr;
        if (ierr || !vld) begin
            m_stat = ierr ? 3'd3 : 3'd4;
            m_halted = 1'b1;
            return;
        end
        step(6'h02, 1'b0);
        step(6'h04, 1'b0);
        cnd = c;
        if (is_mem_icode(ic)) begin
            for (int k = 1; k <= MEM_TIMEOUT; k++) begin
                step(6'h08, 1'b1);
                mem_ack = (k == ack_at);
                if (k == abort_at) begin
                    mem_ack = 1'b0;
                    do_reset();
                    return;
                end
                if (k == ack_at) begin
                    dmem_error = derr;
                    if (derr) begin
                        m_stat = 3'd3; m_halted = 1'b1;
                        return;
                    end
                    break;
                end
                if (k == MEM_TIMEOUT) begin
                    m_stat = 3'd3; m_halted = 1'b1;
                    return;
                end
            end
        end else begin
            step(6'h08, 1'b0);
        end
        step(6'h10, 1'b0);
        step(6'h20, 1'b0);
        valC = vc; valP = vp; valM = vm;
        m_cnt = m_cnt + 32'd1;
        case (ic)
            4'h0: begin m_stat = 3'd2; m_halted = 1'b1; end
            4'h7: m_pc = c ? vc : vp;
            4'h8: m_pc = vc;
            4'h9: m_pc = vm;
            default: m_pc = vp;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_mreq, b_busy, r, ack;
        logic [3:0] ic;
        rst_n = 1'b0;
        noise();
        model_reset();

        run_instr(4'h1, 1, 0, 0, 0, 0, 64'h0, 64'h1, 64'h0, 0);
        chk("nop_pc_model", m_pc, 64'h1);
        chk("nop_cnt_model", 64'(m_cnt), 64'h1);

        run_instr(4'h7, 1, 0, 1, 0, 0, 64'h40, 64'h5, 64'h0, 0);
        chk("jxx_taken_pc", m_pc, 64'h40);
        run_instr(4'h7, 1, 0, 0, 0, 0, 64'h40, 64'h9, 64'h0, 0);
        chk("jxx_fall_pc", m_pc, 64'h9);

        sync(); b_mreq = obs_mreq; b_busy = obs_busy;
        run_instr(4'h5, 1, 0, 0, 4, 0, 64'h0, 64'h13, 64'h0, 0);
        sync();
        chk("mrmovq_mem_req_cycles", 64'(obs_mreq - b_mreq), 64'd4);
        chk("mrmovq_latency", 64'(obs_busy - b_busy), 64'd9);

        run_instr(4'h9, 1, 0, 0, 1, 0, 64'h0, 64'h14, 64'h123, 0);
        chk("ret_pc", m_pc, 64'h123);
        run_instr(4'h8, 1, 0, 0, 2, 0, 64'h200, 64'h12C, 64'h0, 0);
        chk("call_pc", m_pc, 64'h200);
        chk("count_after_call", 64'(m_cnt), 64'd6);

        // halt at pc 0x20
        run_instr(4'h1, 1, 0, 0, 0, 0, 64'h0, 64'h20, 64'h0, 0);
        run_instr(4'h0, 1, 0, 0, 0, 0, 64'h77, 64'h21, 64'h99, 0);
        halted_cycles(22);
        sync();
        chk("halt_stat", 64'(stat), 64'd2);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_pc", pc, 64'h20);
        chk("halt_stage_en", 64'(stage_en), 64'd0);
        chk("halt_count", 64'(instr_count), 64'd8);

        // reset out of HALTED, then an illegal instruction
        do_reset();
        step(6'h01, 1'b0);
        icode = 4'h1; instr_valid = 1'b0; imem_error = 1'b0;
        sync();
        chk("reset_pc", pc, 64'h0);
        chk("reset_stat", 64'(stat), 64'd1);
        chk("reset_stage_en", 64'(stage_en), 64'd1);
        m_stat = 3'd4; m_halted = 1'b1;
        halted_cycles(2);
        sync();
        chk("ins_stat", 64'(stat), 64'd4);
        do_reset();

        // memory timeout
        sync(); b_mreq = obs_mreq;
        run_instr(4'h5, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0);
        halted_cycles(3);
        sync();
        chk("timeout_stat", 64'(stat), 64'd3);
        chk("timeout_mem_req_cycles", 64'(obs_mreq - b_mreq), 64'd15);
        chk("timeout_halted", 64'(halted), 64'd1);
        do_reset();

        // imem_error wins over instr_valid=0
        run_instr(4'h2, 0, 1, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0);
        halted_cycles(2);
        sync();
        chk("imem_prio_stat", 64'(stat), 64'd3);
        do_reset();

        // reset during MEMORY wait
        run_instr(4'h1, 1, 0, 0, 0, 0, 64'h0, 64'h30, 64'h0, 0);
        sync(); b_mreq = obs_mreq;
        run_instr(4'hA, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 3);
        step(6'h01, 1'b0);
        icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
        sync();
        chk("abort_mem_req_cycles", 64'(obs_mreq - b_mreq), 64'd3);
        chk("abort_fetch_mem_req", 64'(mem_req), 64'd0);
        m_pc = m_pc; // FETCH accepted; finish this nop through the generic path below
        step(6'h02, 1'b0); step(6'h04, 1'b0); step(6'h08, 1'b0); step(6'h10, 1'b0);
        step(6'h20, 1'b0);
        valP = 64'h8;
        m_cnt = m_cnt + 32'd1; m_pc = 64'h8;

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 99);
            ic = 4'($urandom);
            if (ic == 4'h0 && r > 8) ic = 4'h6;
            ack = $urandom_range(1, 5);
            if (r == 4) ack = 0;
            if (r == 5) ack = MEM_TIMEOUT;
            run_instr(ic, r != 1, r == 2, 1'($urandom), ack, r == 3,
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0);
            if (m_halted) begin
                halted_cycles($urandom_range(1, 4));
                do_reset();
            end
        end

        step(6'h01, 1'b0);
        icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0;
        sync();
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/y86_seq_controller.md
Name: y86_seq_controller

Overview:
Multi-cycle stage sequencer for the sequential Y86-64 core. Owns the architectural PC register and steps the datapath one stage per cycle: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD. It stretches MEMORY with a data-memory req/ack handshake, selects the next PC, tracks the Y86 status code and counts retired instructions.

Parameters:
PC_W, 64, width of PC and of valC/valM/valP
RESET_PC, 0, PC value loaded on reset
MEM_TIMEOUT, 15, max MEMORY cycles waiting for mem_ack before ADR fault
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
icode  in  4  instruction code from fetch, valid in FETCH cycle
instr_valid  in  1  fetch decoded a legal icode/ifun
imem_error  in  1  fetch address fault
cnd  in  1  condition flag from execute, valid in EXECUTE cycle
valC  in  PC_W  constant word from fetch
valP  in  PC_W  fall-through PC from fetch
valM  in  PC_W  data read from memory
mem_ack  in  1  data-memory completion, sampled only in MEMORY
dmem_error  in  1  data-memory fault, valid with mem_ack
stage_en  out  6  one-hot stage enable {PCUPD,WB,MEM,EXE,DEC,FET}
mem_req  out  1  data-memory access request
pc  out  PC_W  architectural PC
stat  out  3  Y86 status: 1 AOK, 2 HLT, 3 ADR, 4 INS
halted  out  1  core stopped
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (rst_n low at posedge clk): state FETCH, stage_en=6'b000001, pc=RESET_PC, stat=1, halted=0, mem_req=0, instr_count=0, wait counter=0, icode_q=0, cnd_q=0. Reset overrides every state, including mid-MEMORY and HALTED.
- All outputs registered; stage_en is decoded from the state register.
- FETCH (1 cycle): latch icode into icode_q. If imem_error, set stat=3 and go HALTED. Else if !instr_valid, set stat=4 and go HALTED. imem_error takes priority. Otherwise go DECODE.
- DECODE, EXECUTE: 1 cycle each. Latch cnd into cnd_q at the end of EXECUTE.
- MEMORY: memory icodes are 4, 5, 8, 9, A, B.
  - Non-memory icode: 1 cycle, mem_req stays 0.
  - Memory icode: mem_req is 1 from the first MEMORY cycle until the cycle mem_ack is sampled high, then drops to 0 and the FSM goes to WRITEBACK. Minimum stay is 1 cycle (ack in the first cycle).
  - mem_ack with dmem_error: stat=3, go HALTED.
  - Timeout: if MEM_TIMEOUT consecutive MEMORY cycles pass with no ack, stat=3, mem_req=0, go HALTED.
  - mem_ack outside MEMORY is ignored.
- WRITEBACK: 1 cycle.
- PCUPD (1 cycle): next PC is:
  - icode 7: valC if cnd_q else valP.
  - icode 8: valC.
  - icode 9: valM.
  - icode 0 (halt): pc unchanged, stat=2, go HALTED.
  - otherwise: valP.
  - instr_count increments (wraps modulo 2^CNT_W) for every instruction reaching PCUPD, halt included. Non-halt instructions return to FETCH.
- HALTED: stage_en=0, mem_req=0, halted=1; pc, stat and instr_count frozen until reset. Faulting instructions do not increment instr_count and do not change pc.
- Latency: non-memory instruction is 6 cycles; memory instruction is 5 + MEMORY cycles.
- pc is a pure select: no arithmetic, no wrap logic.

Test Plan:
- Reset, then nop (icode=1, valP=0x1) -> stage_en walks 01,02,04,08,10,20; pc=0x1 and instr_count=1 after cycle 6; FETCH again in cycle 7.
- jXX icode=7, cnd=1, valC=0x40 -> pc=0x40. Repeat with cnd=0, valP=0x9 -> pc=0x9.
- mrmovq icode=5, mem_ack asserted on the 4th MEMORY cycle -> mem_req high exactly 4 cycles; instruction takes 9 cycles.
- ret icode=9, valM=0x123 -> pc=0x123. call icode=8, valC=0x200 -> pc=0x200. Both increment instr_count.
- halt icode=0 at pc=0x20 -> stat=2, halted=1, pc stays 0x20, stage_en=0 for 20+ cycles. Then rst_n low for one cycle -> pc=RESET_PC, stat=1, FETCH.
- Faults:
  - icode=5 with mem_ack never asserted -> stat=3 after 15 MEMORY cycles, halted=1.
  - instr_valid=0 -> stat=4.
  - imem_error and instr_valid=0 together -> stat=3.
  - rst_n low during MEMORY wait -> next cycle FETCH, mem_req=0.
